// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, field positions,
// FSM states and register-file geometry.
package id_stage_pkg;

  localparam int REG_COUNT = 8;
  localparam int REG_AW    = 3;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Instruction field positions
  localparam int OP_LSB   = 12;
  localparam int OP_W     = 4;
  localparam int RD_LSB   = 9;
  localparam int RS_LSB   = 6;
  localparam int RT_LSB   = 3;
  localparam int IMM6_W   = 6;
  localparam int IMM12_W  = 12;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_BEQ  = 4'h6,
    OP_BNE  = 4'h7,
    OP_JMP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fsm_state_e;

  // Undefined encodings collapse to NOP so the rest of the stage only sees known opcodes
  function automatic opcode_e decode_op(input logic [OP_W-1:0] raw);
    case (raw)
      4'h1: return OP_ADD;
      4'h2: return OP_SUB;
      4'h3: return OP_AND;
      4'h4: return OP_OR;
      4'h5: return OP_ADDI;
      4'h6: return OP_BEQ;
      4'h7: return OP_BNE;
      4'h8: return OP_JMP;
      4'hF: return OP_HALT;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write
// port. r0 always reads zero. Each read port can optionally see the write
// data in the same cycle (write-first) when its bypass input is set.
module id_stage_regfile
  import id_stage_pkg::*;
#(
  parameter int WORD_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [REG_AW-1:0]   waddr,
  input  logic [WORD_LEN-1:0] wdata,
  input  logic [REG_AW-1:0]   raddr_a,
  input  logic                bypass_a,
  output logic [WORD_LEN-1:0] rdata_a,
  input  logic [REG_AW-1:0]   raddr_b,
  input  logic                bypass_b,
  output logic [WORD_LEN-1:0] rdata_b
);

  logic [WORD_LEN-1:0] mem [REG_COUNT];

  // Storage update; r0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port A with optional write-first forwarding
  always_comb begin
    rdata_a = mem[raddr_a];
    if (raddr_a == '0) begin
      rdata_a = '0;
    end else if (bypass_a && we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
  end

  // Read port B with optional write-first forwarding
  always_comb begin
    rdata_b = mem[raddr_b];
    if (raddr_b == '0) begin
      rdata_b = '0;
    end else if (bypass_b && we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage of the three-stage core. Holds IF/ID and ID/EX registers,
// the register file, branch resolution toward fetch and the RUN/HALT FSM.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | normal decode/issue; branches resolve, stalls may occur
//   ST_HALT | HALT retired in ID; fetch frozen, only bubbles issued to EX
//
// Only ALU instructions (ADD/SUB/AND/OR/ADDI) reach EX as valid entries;
// NOP, branches, JMP and HALT enter ID/EX as all-zero bubbles.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int WORD_LEN = 16
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [WORD_LEN-1:0] PC,
  input  logic [WORD_LEN-1:0] Instruction,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_addr,
  input  logic [WORD_LEN-1:0] wb_data,
  output logic                BranchTK,
  output logic                IncreaseTK,
  output logic [WORD_LEN-1:0] Broffset,
  output logic                ex_valid,
  output logic [OP_W-1:0]     ex_op,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                ex_we,
  output logic [WORD_LEN-1:0] ex_a,
  output logic [WORD_LEN-1:0] ex_b,
  output logic                halted
);

  logic [WORD_LEN-1:0] ifid_pc;
  logic [WORD_LEN-1:0] ifid_instr;
  logic                ifid_valid;

  fsm_state_e state_q, state_d;

  opcode_e             op;
  logic [REG_AW-1:0]   rd, rs, rt;
  logic                is_cmp, is_jmp, is_halt, is_alu;
  logic [WORD_LEN-1:0] imm6_sext, imm12_sext, br_off, br_target;
  logic [REG_AW-1:0]   rf_addr_b;
  logic                rf_bypass;
  logic [WORD_LEN-1:0] rf_a, rf_b;
  logic                hazard, taken;
  logic                stall, squash, issue;

  // Field extraction, classification and branch target/compare
  always_comb begin
    op         = decode_op(ifid_instr[OP_LSB +: OP_W]);
    rd         = ifid_instr[RD_LSB +: REG_AW];
    rs         = ifid_instr[RS_LSB +: REG_AW];
    rt         = ifid_instr[RT_LSB +: REG_AW];
    is_cmp     = ifid_valid && ((op == OP_BEQ) || (op == OP_BNE));
    is_jmp     = ifid_valid && (op == OP_JMP);
    is_halt    = ifid_valid && (op == OP_HALT);
    is_alu     = ifid_valid && ((op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                                (op == OP_OR)  || (op == OP_ADDI));
    // The comparator reads rs/rd straight from the array; keeping wb_data off
    // this path keeps the write-back to PC-redirect path short.
    rf_addr_b  = is_cmp ? rd : rt;
    rf_bypass  = !is_cmp;
    imm6_sext  = {{(WORD_LEN-IMM6_W){ifid_instr[IMM6_W-1]}}, ifid_instr[IMM6_W-1:0]};
    imm12_sext = {{(WORD_LEN-IMM12_W){ifid_instr[IMM12_W-1]}}, ifid_instr[IMM12_W-1:0]};
    br_off     = is_jmp ? imm12_sext : imm6_sext;
    br_target  = ifid_pc + WORD_LEN'(2) + {br_off[WORD_LEN-2:0], 1'b0};
    hazard     = is_cmp && ex_valid && ex_we && (ex_rd != '0) &&
                 ((ex_rd == rs) || (ex_rd == rd));
    taken      = is_jmp || (is_cmp && ((op == OP_BEQ) == (rf_a == rf_b)));
  end

  id_stage_regfile #(
    .WORD_LEN (WORD_LEN)
  ) u_regfile (
    .clk      (clk),
    .rst      (nReset),
    .we       (wb_en),
    .waddr    (wb_addr),
    .wdata    (wb_data),
    .raddr_a  (rs),
    .bypass_a (rf_bypass),
    .rdata_a  (rf_a),
    .raddr_b  (rf_addr_b),
    .bypass_b (rf_bypass),
    .rdata_b  (rf_b)
  );

  // Next state and fetch control, priority: reset > HALT > stall > taken > normal
  always_comb begin
    state_d    = state_q;
    BranchTK   = 1'b0;
    IncreaseTK = 1'b0;
    Broffset   = '0;
    stall      = 1'b0;
    squash     = 1'b0;
    issue      = 1'b0;
    if (!nReset && (state_q == ST_RUN)) begin
      if (is_cmp || is_jmp) begin
        Broffset = br_target;
      end
      if (hazard) begin
        stall = 1'b1;
      end else if (taken) begin
        BranchTK = 1'b1;
        squash   = 1'b1;
      end else begin
        IncreaseTK = 1'b1;
      end
      issue = is_alu && !stall;
      if (is_halt) begin
        state_d = ST_HALT;
      end
    end
  end

  assign halted = (state_q == ST_HALT);

  // FSM state register; HALT is only left through reset
  always_ff @(posedge clk) begin
    if (nReset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // IF/ID register: hold on stall or HALT, NOP on squash, else capture fetch
  always_ff @(posedge clk) begin
    if (nReset) begin
      ifid_pc    <= '0;
      ifid_instr <= WORD_LEN'(NOP_INSTR);
      ifid_valid <= 1'b0;
    end else if ((state_q == ST_HALT) || stall) begin
      ifid_pc    <= ifid_pc;
      ifid_instr <= ifid_instr;
      ifid_valid <= ifid_valid;
    end else if (squash) begin
      ifid_pc    <= '0;
      ifid_instr <= WORD_LEN'(NOP_INSTR);
      ifid_valid <= 1'b0;
    end else begin
      ifid_pc    <= PC;
      ifid_instr <= Instruction;
      ifid_valid <= 1'b1;
    end
  end

  // ID/EX register: ALU instructions issue, everything else is a zero bubble
  always_ff @(posedge clk) begin
    if (nReset || !issue) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_we    <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_op    <= op;
      ex_rd    <= rd;
      ex_we    <= 1'b1;
      ex_a     <= rf_a;
      ex_b     <= (op == OP_ADDI) ? imm6_sext : rf_b;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes expected control values
// (keyed by cycle) and expected EX issues; a monitor on the falling edge
// pops and compares.
module tb_id_stage;

  logic        clk;
  logic        nReset;
  logic [15:0] PC;
  logic [15:0] Instruction;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        BranchTK;
  logic        IncreaseTK;
  logic [15:0] Broffset;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd;
  logic        ex_we;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic        halted;

  id_stage #(.WORD_LEN(16)) dut (
    .clk         (clk),
    .nReset      (nReset),
    .PC          (PC),
    .Instruction (Instruction),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .BranchTK    (BranchTK),
    .IncreaseTK  (IncreaseTK),
    .Broffset    (Broffset),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_rd       (ex_rd),
    .ex_we       (ex_we),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_BTK = 0;
  localparam int S_ITK = 1;
  localparam int S_BRO = 2;
  localparam int S_EXV = 3;
  localparam int S_HLT = 4;
  localparam int S_EXA = 5;

  typedef struct {
    int          at;
    int          sel;
    logic [15:0] val;
  } ctl_exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic        we;
    logic [15:0] a;
    logic [15:0] b;
  } ex_exp_t;

  ctl_exp_t ctl_q[$];
  ex_exp_t  ex_q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sel_name(input int s);
    case (s)
      S_BTK:   return "BranchTK";
      S_ITK:   return "IncreaseTK";
      S_BRO:   return "Broffset";
      S_EXV:   return "ex_valid";
      S_HLT:   return "halted";
      default: return "ex_a";
    endcase
  endfunction

  ctl_exp_t    ce;
  ex_exp_t     xe;
  logic [15:0] act;

  // Monitor: control checks due this cycle, then any EX issue
  always @(negedge clk) begin
    while (ctl_q.size() > 0 && ctl_q[0].at <= cyc) begin
      ce = ctl_q.pop_front();
      case (ce.sel)
        S_BTK:   act = {15'b0, BranchTK};
        S_ITK:   act = {15'b0, IncreaseTK};
        S_BRO:   act = Broffset;
        S_EXV:   act = {15'b0, ex_valid};
        S_HLT:   act = {15'b0, halted};
        default: act = ex_a;
      endcase
      checks++;
      if (act !== ce.val) begin
        errors++;
        $display("FAIL %s cyc %0d: got %h want %h", sel_name(ce.sel), cyc, act, ce.val);
      end
    end
    if (ex_valid === 1'b1) begin
      checks++;
      if (ex_q.size() == 0) begin
        errors++;
        $display("FAIL ex_issue cyc %0d: got unexpected op %h rd %0d want no issue", cyc, ex_op, ex_rd);
      end else begin
        xe = ex_q.pop_front();
        if ({ex_op, ex_rd, ex_we, ex_a, ex_b} !== {xe.op, xe.rd, xe.we, xe.a, xe.b}) begin
          errors++;
          $display("FAIL ex_issue cyc %0d: got op %h rd %0d we %b a %h b %h want op %h rd %0d we %b a %h b %h",
                   cyc, ex_op, ex_rd, ex_we, ex_a, ex_b, xe.op, xe.rd, xe.we, xe.a, xe.b);
        end
      end
    end
  end

  task automatic expect_ctl(input int sel, input logic [15:0] v);
    ctl_q.push_back('{cyc, sel, v});
  endtask

  task automatic expect_ex(input logic [3:0] op, input logic [2:0] rd, input logic [15:0] a,
                           input logic [15:0] b);
    ex_q.push_back('{op, rd, 1'b1, a, b});
  endtask

  // Present one fetch word (and EX write-back) for a cycle; on return the
  // word sits in IF/ID unless it was held or squashed.
  task automatic tick(input logic [15:0] pc_i, input logic [15:0] instr_i, input logic we_i,
                      input logic [2:0] wa_i, input logic [15:0] wd_i);
    PC          = pc_i;
    Instruction = instr_i;
    wb_en       = we_i;
    wb_addr     = wa_i;
    wb_data     = wd_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nReset      = 1'b1;
    PC          = 16'h0000;
    Instruction = 16'h1000;
    wb_en       = 1'b0;
    wb_addr     = 3'd0;
    wb_data     = 16'h0000;

    // reset held across two edges
    @(posedge clk); #1;
    expect_ctl(S_BTK, 16'd0); expect_ctl(S_ITK, 16'd0);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_BRO, 16'h0000);
    @(posedge clk); #1;
    nReset = 1'b0;
    Instruction = 16'h0000;
    expect_ctl(S_ITK, 16'd1); expect_ctl(S_BTK, 16'd0); expect_ctl(S_HLT, 16'd0);

    // preload r1 = r2 = 5
    tick(16'h0000, 16'h0000, 1'b1, 3'd1, 16'd5);
    tick(16'h0002, 16'h0000, 1'b1, 3'd2, 16'd5);

    // BEQ r1,r2,+3 at 0x0010: taken, target 0x0018
    tick(16'h0010, 16'h6283, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_BTK, 16'd1); expect_ctl(S_ITK, 16'd0); expect_ctl(S_BRO, 16'h0018);
    // HALT behind the taken branch is squashed
    tick(16'h0012, 16'hF000, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_ITK, 16'd1);
    expect_ctl(S_BTK, 16'd0); expect_ctl(S_BRO, 16'h0000);

    // ADD r5,r1,r2
    tick(16'h0018, 16'h1A50, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_HLT, 16'd0);
    expect_ex(4'h1, 3'd5, 16'd5, 16'd5);
    tick(16'h001A, 16'h0000, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_HLT, 16'd0);

    // ADDI r1,r0,#7 then BEQ r1,r0,+5: one stall, then not taken
    tick(16'h0020, 16'h5207, 1'b0, 3'd0, 16'h0);
    expect_ex(4'h5, 3'd1, 16'd0, 16'd7);
    tick(16'h0022, 16'h6205, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_ITK, 16'd0); expect_ctl(S_BTK, 16'd0); expect_ctl(S_BRO, 16'h002E);
    tick(16'h0024, 16'h0000, 1'b1, 3'd1, 16'd7);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_ITK, 16'd1);
    expect_ctl(S_BTK, 16'd0); expect_ctl(S_BRO, 16'h002E);
    tick(16'h0024, 16'h0000, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_EXV, 16'd0);

    // ADD r4,r3,r0 with r3 written the same cycle: write-first
    tick(16'h0026, 16'h18C0, 1'b0, 3'd0, 16'h0);
    expect_ex(4'h1, 3'd4, 16'h1234, 16'h0000);
    tick(16'h0028, 16'h0000, 1'b1, 3'd3, 16'h1234);
    expect_ctl(S_EXA, 16'h1234);

    // ALU mix
    tick(16'h002A, 16'h1CD8, 1'b0, 3'd0, 16'h0);
    expect_ex(4'h1, 3'd6, 16'h1234, 16'h1234);
    tick(16'h002C, 16'h54FF, 1'b0, 3'd0, 16'h0);
    expect_ex(4'h5, 3'd2, 16'h1234, 16'hFFFF);
    tick(16'h002E, 16'h2E50, 1'b0, 3'd0, 16'h0);
    expect_ex(4'h2, 3'd7, 16'd7, 16'd5);
    tick(16'h0030, 16'h4688, 1'b0, 3'd0, 16'h0);
    expect_ex(4'h4, 3'd3, 16'd5, 16'd7);

    // undefined opcode decodes as NOP, then ADD r2 feeding a BNE on rs
    tick(16'h0032, 16'h9FFF, 1'b0, 3'd0, 16'h0);
    tick(16'h0034, 16'h1480, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_EXV, 16'd0);
    expect_ex(4'h1, 3'd2, 16'd5, 16'd0);
    tick(16'h0040, 16'h72BE, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_ITK, 16'd0); expect_ctl(S_BTK, 16'd0); expect_ctl(S_BRO, 16'h003E);
    tick(16'h0042, 16'h0000, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_BTK, 16'd1);
    expect_ctl(S_ITK, 16'd0); expect_ctl(S_BRO, 16'h003E);
    tick(16'h0044, 16'h0000, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_ITK, 16'd1);

    // JMP -1 at 0xFFFE wraps back to 0xFFFE
    tick(16'hFFFE, 16'h8FFF, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_BTK, 16'd1); expect_ctl(S_ITK, 16'd0); expect_ctl(S_BRO, 16'hFFFE);
    tick(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0);

    // HALT: fetch frozen, later instructions ignored
    tick(16'h0050, 16'hF000, 1'b0, 3'd0, 16'h0);
    tick(16'h0052, 16'h1A50, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_HLT, 16'd1); expect_ctl(S_ITK, 16'd0); expect_ctl(S_BTK, 16'd0);
    tick(16'h0054, 16'h1A50, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_HLT, 16'd1); expect_ctl(S_ITK, 16'd0);
    tick(16'h0056, 16'h0000, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_ITK, 16'd0);

    // reset leaves HALT
    nReset = 1'b1;
    tick(16'h0060, 16'h0000, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_HLT, 16'd0); expect_ctl(S_EXV, 16'd0);
    nReset = 1'b0;
    expect_ctl(S_ITK, 16'd1);

    // reset during a taken branch: no redirect survives
    tick(16'h0010, 16'h6243, 1'b0, 3'd0, 16'h0);
    nReset = 1'b1;
    expect_ctl(S_BTK, 16'd0); expect_ctl(S_BRO, 16'h0000); expect_ctl(S_ITK, 16'd0);
    tick(16'h0012, 16'h0000, 1'b0, 3'd0, 16'h0);
    nReset = 1'b0;
    expect_ctl(S_BTK, 16'd0); expect_ctl(S_ITK, 16'd1);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_BRO, 16'h0000);
    tick(16'h0014, 16'h0000, 1'b0, 3'd0, 16'h0);
    expect_ctl(S_EXV, 16'd0); expect_ctl(S_BTK, 16'd0);

    repeat (3) tick(16'h0016, 16'h0000, 1'b0, 3'd0, 16'h0);

    checks++;
    if (ex_q.size() != 0) begin
      errors++;
      $display("FAIL ex_drain: got %0d issues outstanding want 0", ex_q.size());
    end
    checks++;
    if (ctl_q.size() != 0) begin
      errors++;
      $display("FAIL ctl_drain: got %0d checks outstanding want 0", ctl_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 16-bit three-stage core (IF -> ID -> EX), sitting directly downstream of the fetch stage.
- Captures PC/Instruction into an IF/ID register and decodes the instruction.
- Holds the 8x16 register file, resolves branches and jumps, and drives BranchTK/IncreaseTK/Broffset back to fetch.
- Issues operands to EX through an ID/EX register. Handles branch-dependency stalls, taken-branch squash and HALT.

Parameters:
WORD_LEN, 16, datapath/PC width
REG_COUNT, 8, architectural registers (r0 reads 0, writes ignored)
NOP_INSTR, 16'h0000, instruction injected on squash/bubble

Ports:
clk  in  1  clock, rising edge
nReset  in  1  synchronous, active-high reset (asserted = 1)
PC  in  WORD_LEN  address of Instruction from fetch
Instruction  in  WORD_LEN  fetched instruction
wb_en  in  1  EX write-back enable
wb_addr  in  3  EX write-back register
wb_data  in  WORD_LEN  EX write-back value
BranchTK  out  1  load Broffset into PC
IncreaseTK  out  1  advance PC by 2 (0 = hold PC)
Broffset  out  WORD_LEN  absolute branch/jump target
ex_valid  out  1  ID/EX holds a real instruction
ex_op  out  4  opcode to EX
ex_rd  out  3  destination register
ex_we  out  1  EX result is written back
ex_a  out  WORD_LEN  operand A (rs)
ex_b  out  WORD_LEN  operand B (rt or sign-extended imm6)
halted  out  1  FSM in HALT

Behaviour:
- Encoding: op[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0], imm12[11:0].
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 BEQ (rs,rd compare), 7 BNE, 8 JMP, F HALT. Undefined opcodes decode as NOP.
- Reset (synchronous, nReset=1 at edge):
  - IF/ID <= {NOP_INSTR, pc 0, valid 0}; ID/EX all 0; register file all 0; FSM <= RUN.
  - While nReset=1, BranchTK=0, IncreaseTK=0, Broffset=0.
- IF/ID register: each cycle loads {PC, Instruction, valid=1} unless stalled (hold) or squashed (load NOP, valid 0).
- Register file: write at clock edge when wb_en && wb_addr!=0.
  - ALU operand reads are write-first: if wb_en and wb_addr matches the read address, use wb_data.
  - The branch comparator reads the array only (no bypass), to keep the wb->PC path short.
- Branch stall: BEQ/BNE valid in ID, ID/EX has ex_valid && ex_we && ex_rd!=0, and ex_rd equals the branch rs or rd -> stall for 1 cycle.
  - During the stall: IF/ID held, IncreaseTK=0, BranchTK=0, bubble (all zero) into ID/EX.
- Branch resolution:
  - Combinational outputs, same cycle the branch is in ID and not stalled. Latency 0 from IF/ID to BranchTK.
  - Target = ifid_pc + 2 + (sext(imm6) << 1) for BEQ/BNE; ifid_pc + 2 + (sext(imm12) << 1) for JMP. Modulo 2^16 wrap.
  - Taken: BranchTK=1, IncreaseTK=0, Broffset=target. Squash IF/ID at next edge.
  - Not-taken: BranchTK=0, IncreaseTK=1.
  - Branches and JMP issue as ex_we=0 bubbles into EX.
- Broffset equals the computed target whenever a branch/JMP is in ID, else 0.
- Default (RUN, no stall/branch): IncreaseTK=1, BranchTK=0.
- ID/EX: registered, 1 cycle after IF/ID.
  - ex_we=1 for ADD/SUB/AND/OR/ADDI; ex_b = sext(imm6) for ADDI.
- FSM RUN/HALT:
  - RUN -> HALT when a valid HALT is in ID and not squashed.
  - HALT: IncreaseTK=0, BranchTK=0, bubbles into ID/EX, halted=1.
  - HALT is left only by reset.
- Priority: reset > HALT > stall > taken branch > normal.
- A HALT arriving in IF/ID the cycle a taken branch squashes it is discarded.
- Reset mid-stall or mid-branch: all state cleared at that edge; no pending redirect survives.

Decomposition:
- Shared package: opcode enum, instruction field position constants, fsm state enum (RUN/HALT), NOP_INSTR, REG_COUNT.
- WORD_LEN stays with the existing width constants.
- One sub-module: regfile (8x16, two async read ports, one sync write port, write-first option per port).

Test Plan:
- Reset held 2 cycles with Instruction=16'h1000 -> BranchTK=0, IncreaseTK=0, ex_valid=0. First cycle after release: IncreaseTK=1.
- wb r1=5 and r2=5 preloaded; BEQ r1,r2,imm6=+3 at PC=0x0010 -> same cycle BranchTK=1, Broffset=0x0018. Next cycle ex_valid=0 (squash).
- ADDI r1,r0,#7 then BEQ r1,r0 -> one stall cycle (IncreaseTK=0, bubble into EX), then not-taken, IncreaseTK=1.
- wb_en=1, wb_addr=3, wb_data=0x1234 with ADD r4,r3,r0 in ID -> next cycle ex_a=0x1234 (write-first bypass).
- JMP imm12=0xFFF at PC=0xFFFE -> Broffset=0xFFFE (wrap).
- HALT in ID -> halted=1 from next cycle, IncreaseTK=0 thereafter, ignores later Instruction; reset returns to RUN.
